// File: rtl/cdb_arbiter_buffer.sv
// Per-source result FIFOs with round-robin arbitration onto a registered common data bus.
// Optional macro CDB_ARB_STALL_CNT_EN adds per-source saturating stall counters (o_stall_cnt).
module cdb_arbiter_buffer #(
  parameter int NUM_SRC    = 4,
  parameter int BW_TAG     = 6,
  parameter int BW_DATA    = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic [NUM_SRC-1:0]           i_src_valid,
  input  logic [NUM_SRC*BW_TAG-1:0]    i_src_tag,
  input  logic [NUM_SRC*BW_DATA-1:0]   i_src_data,
  output logic [NUM_SRC-1:0]           o_src_ready,
  output logic                         o_cdb_valid,
  output logic [BW_TAG-1:0]            o_cdb_tag,
  output logic [BW_DATA-1:0]           o_cdb_data,
  output logic [$clog2(NUM_SRC)-1:0]   o_cdb_src,
  input  logic                         i_cdb_ready
`ifdef CDB_ARB_STALL_CNT_EN
  ,
  output logic [NUM_SRC*16-1:0]        o_stall_cnt
`endif
);
  localparam int SW = $clog2(NUM_SRC);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = BW_TAG + BW_DATA;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [EW-1:0]   mem_q [NUM_SRC][FIFO_DEPTH];
  logic [EW-1:0]   mem_d [NUM_SRC][FIFO_DEPTH];
  logic [AW-1:0]   rd_q  [NUM_SRC];
  logic [AW-1:0]   rd_d  [NUM_SRC];
  logic [AW-1:0]   wr_q  [NUM_SRC];
  logic [AW-1:0]   wr_d  [NUM_SRC];
  logic [CW-1:0]   cnt_q [NUM_SRC];
  logic [CW-1:0]   cnt_d [NUM_SRC];
  logic [SW-1:0]   ptr_q, ptr_d;
  logic            valid_q, valid_d;
  logic [BW_TAG-1:0]  tag_q, tag_d;
  logic [BW_DATA-1:0] data_q, data_d;
  logic [SW-1:0]   src_q, src_d;

  logic [NUM_SRC-1:0] nonempty_s;
  logic [NUM_SRC-1:0] push_s;
  logic [NUM_SRC-1:0] pop_s;
  logic               load_en_s;
  logic               grant_vld_s;
  logic [SW-1:0]      grant_idx_s;

`ifdef CDB_ARB_STALL_CNT_EN
  logic [15:0] stall_q [NUM_SRC];
  logic [15:0] stall_d [NUM_SRC];
`endif

  // Modulo-NUM_SRC add for offsets below NUM_SRC.
  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_SRC) begin
      wrap_add = SW'(sum - NUM_SRC);
    end else begin
      wrap_add = SW'(sum);
    end
  endfunction

  // Ready and occupancy flags depend on FIFO state only.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      o_src_ready[k] = (cnt_q[k] < DEPTH_C);
      nonempty_s[k]  = (cnt_q[k] != '0);
      push_s[k]      = i_src_valid[k] && o_src_ready[k];
    end
  end

  // Walk offsets downward so the closest non-empty FIFO to the pointer wins last.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      grant_idx_s = nonempty_s[wrap_add(ptr_q, i)] ? wrap_add(ptr_q, i) : grant_idx_s;
      grant_vld_s = grant_vld_s | nonempty_s[wrap_add(ptr_q, i)];
    end
  end

  // Next-state for FIFOs, output register, pointer and stall counters.
  always_comb begin
    load_en_s = !valid_q || i_cdb_ready;
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    src_d   = src_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      pop_s[k] = load_en_s && grant_vld_s && (grant_idx_s == SW'(k));
      if (push_s[k]) begin
        mem_d[k][wr_q[k]] = {i_src_tag[k*BW_TAG +: BW_TAG], i_src_data[k*BW_DATA +: BW_DATA]};
        wr_d[k] = wr_q[k] + AW'(1);
      end else begin
        wr_d[k] = wr_q[k];
      end
      if (pop_s[k]) begin
        rd_d[k] = rd_q[k] + AW'(1);
      end else begin
        rd_d[k] = rd_q[k];
      end
      case ({push_s[k], pop_s[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + CW'(1);
        2'b01:   cnt_d[k] = cnt_q[k] - CW'(1);
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
    if (load_en_s) begin
      if (grant_vld_s) begin
        valid_d          = 1'b1;
        {tag_d, data_d}  = mem_q[grant_idx_s][rd_q[grant_idx_s]];
        src_d            = grant_idx_s;
        ptr_d            = wrap_add(grant_idx_s, 1);
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
`ifdef CDB_ARB_STALL_CNT_EN
    for (int k = 0; k < NUM_SRC; k++) begin
      if (nonempty_s[k] && !pop_s[k] && (stall_q[k] != 16'hFFFF)) begin
        stall_d[k] = stall_q[k] + 16'd1;
      end else begin
        stall_d[k] = stall_q[k];
      end
    end
`endif
    // Flush drops buffered results, the pending broadcast and same-cycle writes.
    if (i_flush) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        rd_d[k]  = '0;
        wr_d[k]  = '0;
        cnt_d[k] = '0;
`ifdef CDB_ARB_STALL_CNT_EN
        stall_d[k] = 16'd0;
`endif
      end
      valid_d = 1'b0;
      ptr_d   = '0;
    end else begin
      ptr_d = ptr_d;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        for (int e = 0; e < FIFO_DEPTH; e++) begin
          mem_q[k][e] <= '0;
        end
        rd_q[k]  <= '0;
        wr_q[k]  <= '0;
        cnt_q[k] <= '0;
`ifdef CDB_ARB_STALL_CNT_EN
        stall_q[k] <= 16'd0;
`endif
      end
      ptr_q   <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
`ifdef CDB_ARB_STALL_CNT_EN
      stall_q <= stall_d;
`endif
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign o_cdb_valid = valid_q;
  assign o_cdb_tag   = tag_q;
  assign o_cdb_data  = data_q;
  assign o_cdb_src   = src_q;

`ifdef CDB_ARB_STALL_CNT_EN
  // Pack stall counters like the source inputs.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      o_stall_cnt[k*16 +: 16] = stall_q[k];
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter_buffer.sv
// Scoreboard bench for cdb_arbiter_buffer: queue-based reference model, directed and random traffic.
module tb_cdb_arbiter_buffer;
  localparam int N  = 4;
  localparam int TW = 6;
  localparam int DW = 32;
  localparam int D  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_flush = 1'b0;
  logic [N-1:0]    i_src_valid = '0;
  logic [N*TW-1:0] i_src_tag = '0;
  logic [N*DW-1:0] i_src_data = '0;
  logic [N-1:0]    o_src_ready;
  logic            o_cdb_valid;
  logic [TW-1:0]   o_cdb_tag;
  logic [DW-1:0]   o_cdb_data;
  logic [1:0]      o_cdb_src;
  logic            i_cdb_ready = 1'b0;
`ifdef CDB_ARB_STALL_CNT_EN
  logic [N*16-1:0] o_stall_cnt;
`endif

  always #5 clk = ~clk;

  cdb_arbiter_buffer #(.NUM_SRC(N), .BW_TAG(TW), .BW_DATA(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
    .i_src_valid(i_src_valid), .i_src_tag(i_src_tag), .i_src_data(i_src_data),
    .o_src_ready(o_src_ready), .o_cdb_valid(o_cdb_valid), .o_cdb_tag(o_cdb_tag),
    .o_cdb_data(o_cdb_data), .o_cdb_src(o_cdb_src), .i_cdb_ready(i_cdb_ready)
`ifdef CDB_ARB_STALL_CNT_EN
    , .o_stall_cnt(o_stall_cnt)
`endif
  );

  typedef struct packed {
    logic [1:0]    src;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  int   checks = 0;
  int   failures = 0;
  ent_t fq[N][$];
  ent_t exp_q[$];
  int   m_ptr = 0;
  bit   m_valid = 1'b0;
  int   m_stall[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      fq[k].delete();
      m_stall[k] = 0;
    end
    exp_q.delete();
    m_ptr = 0;
    m_valid = 1'b0;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = (fq[k].size() < D);
    return r;
  endfunction

  // Advance the reference model by one clock edge using the inputs just applied.
  function automatic void model_step();
    bit   load;
    int   g;
    bit   acc[N];
    ent_t e;
    if (i_flush) begin
      model_reset();
      return;
    end
    load = !m_valid || i_cdb_ready;
    g = -1;
    if (load) begin
      for (int i = 0; i < N; i++) begin
        int s;
        s = (m_ptr + i) % N;
        if (g < 0 && fq[s].size() > 0) g = s;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (fq[k].size() > 0 && k != g && m_stall[k] < 65535) m_stall[k]++;
      acc[k] = i_src_valid[k] && (fq[k].size() < D);
    end
    e = '0;
    if (g >= 0) e = fq[g].pop_front();
    for (int k = 0; k < N; k++) begin
      if (acc[k]) fq[k].push_back({2'(k), i_src_tag[k*TW +: TW], i_src_data[k*DW +: DW]});
    end
    if (load) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_ptr = (g + 1) % N;
        exp_q.push_back(e);
      end else begin
        m_valid = 1'b0;
      end
    end
  endfunction

  // Monitor: checks handshake state every cycle and pops the scoreboard on each consumed broadcast.
  always @(negedge clk) begin : monitor
    ent_t e;
    if (rst_n) begin
      chk("cdb_valid", 64'(o_cdb_valid), 64'(m_valid));
      chk("src_ready", 64'(o_src_ready), 64'(model_ready()));
`ifdef CDB_ARB_STALL_CNT_EN
      for (int k = 0; k < N; k++) chk("stall_cnt", 64'(o_stall_cnt[k*16 +: 16]), 64'(m_stall[k]));
`endif
      if (o_cdb_valid && i_cdb_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL cdb_unexpected actual=src%0d tag=%0h required=no broadcast", o_cdb_src, o_cdb_tag);
        end else begin
          e = exp_q.pop_front();
          chk("cdb_src", 64'(o_cdb_src), 64'(e.src));
          chk("cdb_tag", 64'(o_cdb_tag), 64'(e.tag));
          chk("cdb_data", 64'(o_cdb_data), 64'(e.data));
        end
      end
    end
  end

  task automatic step(input logic [N-1:0] v, input logic rdy, input logic fl, input bit rnd);
    i_src_valid = v;
    i_cdb_ready = rdy;
    i_flush = fl;
    if (rnd) begin
      for (int k = 0; k < N; k++) begin
        i_src_tag[k*TW +: TW] = TW'($urandom);
        i_src_data[k*DW +: DW] = $urandom;
      end
    end
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic check_reset_outputs(input string tagname);
    chk({tagname, "_valid"}, 64'(o_cdb_valid), 64'd0);
    chk({tagname, "_tag"}, 64'(o_cdb_tag), 64'd0);
    chk({tagname, "_data"}, 64'(o_cdb_data), 64'd0);
    chk({tagname, "_src"}, 64'(o_cdb_src), 64'd0);
    chk({tagname, "_ready"}, 64'(o_src_ready), 64'hF);
`ifdef CDB_ARB_STALL_CNT_EN
    chk({tagname, "_stall"}, 64'(o_stall_cnt), 64'd0);
`endif
  endtask

  // Asynchronous reset applied between clock edges, released away from the negedge monitor.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    i_src_valid = '0;
    i_cdb_ready = 1'b0;
    i_flush = 1'b0;
    #1;
    check_reset_outputs("reset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [TW-1:0] t0, t1, t2;

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single source: src1 tag 5 / data A5.
    i_src_tag[1*TW +: TW] = 6'd5;
    i_src_data[1*DW +: DW] = 32'hA5;
    step(4'b0010, 1'b1, 1'b0, 1'b0);
    chk("single_not_early", 64'(o_cdb_valid), 64'd0);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    chk("single_valid", 64'(o_cdb_valid), 64'd1);
    chk("single_tag", 64'(o_cdb_tag), 64'd5);
    chk("single_data", 64'(o_cdb_data), 64'hA5);
    chk("single_src", 64'(o_cdb_src), 64'd1);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    chk("single_drained", 64'(o_cdb_valid), 64'd0);

    // All-source contention after reset: 0,1,2,3 then idle.
    do_reset();
    step(4'b1111, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) begin
      step(4'b0000, 1'b1, 1'b0, 1'b1);
      chk("contend_valid", 64'(o_cdb_valid), 64'd1);
      chk("contend_src", 64'(o_cdb_src), 64'(i));
`ifdef CDB_ARB_STALL_CNT_EN
      if (i == 2) chk("stall_src3", 64'(o_stall_cnt[3*16 +: 16]), 64'd3);
`endif
    end
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    chk("contend_idle", 64'(o_cdb_valid), 64'd0);

    // Back-pressure: src2 pushes three results while the bus stalls.
    do_reset();
    step(4'b0100, 1'b0, 1'b0, 1'b1);
    t0 = i_src_tag[2*TW +: TW];
    step(4'b0100, 1'b0, 1'b0, 1'b1);
    t1 = i_src_tag[2*TW +: TW];
    step(4'b0100, 1'b0, 1'b0, 1'b1);
    t2 = i_src_tag[2*TW +: TW];
    chk("full_ready", 64'(o_src_ready), 64'hB);
    chk("full_head", 64'(o_cdb_tag), 64'(t0));
    step(4'b0100, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("hold_tag", 64'(o_cdb_tag), 64'(t0));
    chk("hold_src", 64'(o_cdb_src), 64'd2);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    chk("order_1", 64'(o_cdb_tag), 64'(t1));
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    chk("order_2", 64'(o_cdb_tag), 64'(t2));
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    chk("order_done", 64'(o_cdb_valid), 64'd0);

    // Wrap-around: pointer at 3 with FIFO0 and FIFO3 pending.
    do_reset();
    step(4'b0100, 1'b1, 1'b0, 1'b1);
    step(4'b1001, 1'b1, 1'b0, 1'b1);
    chk("wrap_first", 64'(o_cdb_src), 64'd2);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    chk("wrap_src3", 64'(o_cdb_src), 64'd3);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    chk("wrap_src0", 64'(o_cdb_src), 64'd0);
    step(4'b0010, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    chk("wrap_ptr1", 64'(o_cdb_src), 64'd1);

    // Flush with pending results and a same-cycle src0 push.
    do_reset();
    step(4'b1111, 1'b0, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b0, 1'b1);
    chk("preflush_valid", 64'(o_cdb_valid), 64'd1);
    step(4'b0001, 1'b0, 1'b1, 1'b1);
    chk("flush_valid", 64'(o_cdb_valid), 64'd0);
    chk("flush_ready", 64'(o_src_ready), 64'hF);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    chk("flush_dropped", 64'(o_cdb_valid), 64'd0);
    step(4'b0010, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    chk("flush_ptr0", 64'(o_cdb_src), 64'd1);

    // Reset asserted mid-operation.
    step(4'b1111, 1'b0, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b0, 1'b1);
    do_reset();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      step(4'($urandom), ($urandom_range(0, 3) != 0) || (c % 400 < 40) ? 1'b1 : 1'b0,
           ($urandom_range(0, 150) == 0) ? 1'b1 : 1'b0, 1'b1);
    end
    for (int c = 0; c < 20; c++) step(4'b0000, 1'b1, 1'b0, 1'b1);
    chk("drain_valid", 64'(o_cdb_valid), 64'd0);
    chk("drain_scoreboard", 64'(exp_q.size()), 64'd0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
